// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the async FIFO: Gray write pointer, read-pointer synchroniser, registered full flag.
// Build option FIFO_WR_LEVEL_EN adds the write-side occupancy (wlevel) and almost-full outputs.
module fifo_wr_ctrl #(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [DATASIZE-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [DATASIZE-1:0] wdata,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic                wfull,
    output logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full
);

    localparam int DEPTH = 1 << ADDRSIZE;

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_wr_ctrl: AFULL_THRESH must lie in 1..DEPTH");
    end

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbnext;
    logic [ADDRSIZE:0] wgnext;
    logic [ADDRSIZE:0] wq1_rptr;
    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] rptr_full_cmp;
    logic              rdy_q;
    logic              winc;

    assign s_tready = rdy_q & ~wfull;
    assign winc     = s_tvalid & s_tready;
    assign wclken   = winc;
    assign wdata    = s_tdata;
    assign waddr    = wbin[ADDRSIZE-1:0];

    assign wbnext = wbin + {{ADDRSIZE{1'b0}}, winc};
    assign wgnext = (wbnext >> 1) ^ wbnext;

    // Full when the next write pointer equals the read pointer with its two MSBs inverted (Gray wrap).
    assign rptr_full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin     <= '0;
            wptr     <= '0;
            wq1_rptr <= '0;
            wq2_rptr <= '0;
            wfull    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            wbin     <= wbnext;
            wptr     <= wgnext;
            wq1_rptr <= rptr;
            wq2_rptr <= wq1_rptr;
            wfull    <= (wgnext == rptr_full_cmp);
            rdy_q    <= 1'b1;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    localparam logic [ADDRSIZE:0] AFULL_LVL = AFULL_THRESH[ADDRSIZE:0];

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] rbin_sync;

    assign rbin_sync    = gray2bin(wq2_rptr);
    assign wlevel       = wbin - rbin_sync;
    assign walmost_full = (wlevel >= AFULL_LVL);
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: accepted writes are scoreboarded, status outputs checked against hand values.
// Level expectations follow FIFO_WR_LEVEL_EN (zero when the macro is undefined).
module tb_fifo_wr_ctrl;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 4;

`ifdef FIFO_WR_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic                wclk = 1'b0;
    logic                wrst_n;
    logic [DATASIZE-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tready;
    logic [DATASIZE-1:0] wdata;
    logic [ADDRSIZE-1:0] waddr;
    logic                wclken;
    logic                wfull;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   wlevel;
    logic                walmost_full;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    fifo_wr_ctrl #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE), .AFULL_THRESH(12)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .wdata(wdata), .waddr(waddr), .wclken(wclken),
        .wfull(wfull), .wptr(wptr), .rptr(rptr), .wlevel(wlevel),
        .walmost_full(walmost_full)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic int lvl(input int n);
        return LVL_EN ? n : 0;
    endfunction

    task automatic push_beat(input int addr, input int data);
        logic [11:0] e;
        e[11:8] = addr[3:0];
        e[7:0]  = data[7:0];
        exp_q.push_back(e);
    endtask

    // Reset asserted mid-cycle, held across one edge, released mid-cycle, then one edge to readiness.
    task automatic reset_cycle();
        s_tvalid = 1'b0;
        rptr     = '0;
        #2;
        wrst_n = 1'b0;
        #1;
        chk("rst_async_wptr", int'(wptr), 0);
        chk("rst_async_waddr", int'(waddr), 0);
        chk("rst_async_wfull", int'(wfull), 0);
        chk("rst_async_tready", int'(s_tready), 0);
        tick();
        #2;
        wrst_n = 1'b1;
        #1;
        chk("rel_tready_before_edge", int'(s_tready), 0);
        tick();
        chk("rel_tready_after_edge", int'(s_tready), 1);
    endtask

    task automatic monitor();
        logic [11:0] e;
        forever begin
            @(negedge wclk);
            if (wrst_n && wclken) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: waddr %0d wdata 0x%0h, none expected at %0t", waddr, wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_waddr", int'(waddr), int'(e[11:8]));
                    chk("sb_wdata", int'(wdata), int'(e[7:0]));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset with a pending request: everything quiet.
        wrst_n   = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = '0;
        rptr     = '0;
        #22;
        chk("rst_tready", int'(s_tready), 0);
        chk("rst_wclken", int'(wclken), 0);
        chk("rst_wfull", int'(wfull), 0);
        chk("rst_wptr", int'(wptr), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_wlevel", int'(wlevel), 0);
        chk("rst_afull", int'(walmost_full), 0);
        s_tvalid = 1'b0;
        wrst_n   = 1'b1;
        #1;
        chk("rel_tready_0", int'(s_tready), 0);
        tick();
        chk("rel_tready_1", int'(s_tready), 1);

        // Fill 16 beats.
        for (int i = 0; i < 16; i++) begin
            s_tdata  = 8'(i);
            s_tvalid = 1'b1;
            push_beat(i, i);
            tick();
            chk("fill_wfull", int'(wfull), (i == 15) ? 1 : 0);
        end
        s_tdata = 8'h10;
        chk("full_wptr", int'(wptr), 5'b11000);
        chk("full_tready", int'(s_tready), 0);
        chk("full_wlevel", int'(wlevel), lvl(16));

        // Stall while full.
        for (int i = 0; i < 5; i++) begin
            chk("stall_wclken", int'(wclken), 0);
            tick();
            chk("stall_wptr", int'(wptr), 5'b11000);
            chk("stall_wfull", int'(wfull), 1);
        end

        // Read pointer advances to 4; full clears on the third edge.
        rptr = 5'b00110;
        tick();
        chk("drain_e1_wfull", int'(wfull), 1);
        tick();
        chk("drain_e2_wfull", int'(wfull), 1);
        tick();
        chk("drain_e3_wfull", int'(wfull), 0);
        chk("drain_wlevel", int'(wlevel), lvl(12));
        chk("drain_afull", int'(walmost_full), LVL_EN ? 1 : 0);
        for (int k = 0; k < 4; k++) begin
            s_tdata = 8'(8'h10 + k);
            push_beat(k, 8'h10 + k);
            tick();
            chk("wrap_wfull", int'(wfull), (k == 3) ? 1 : 0);
        end
        chk("wrap_wptr", int'(wptr), 5'b11110);

        // Asynchronous reset while full.
        reset_cycle();

        // Level from empty.
        for (int i = 0; i < 12; i++) begin
            s_tdata  = 8'(8'h40 + i);
            s_tvalid = 1'b1;
            push_beat(i, 8'h40 + i);
            tick();
            if (i == 10) begin
                chk("lvl11_wlevel", int'(wlevel), lvl(11));
                chk("lvl11_afull", int'(walmost_full), 0);
            end
        end
        s_tvalid = 1'b0;
        chk("lvl12_wlevel", int'(wlevel), lvl(12));
        chk("lvl12_afull", int'(walmost_full), LVL_EN ? 1 : 0);
        chk("lvl12_wfull", int'(wfull), 0);

        // Seven writes then asynchronous reset.
        reset_cycle();
        for (int i = 0; i < 7; i++) begin
            s_tdata  = 8'(8'h80 + i);
            s_tvalid = 1'b1;
            push_beat(i, 8'h80 + i);
            tick();
        end
        s_tvalid = 1'b0;
        chk("w7_wptr", int'(wptr), 5'b00100);
        chk("w7_waddr", int'(waddr), 7);
        reset_cycle();

        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
